// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multicycle MIPS-style datapath. It sequences fetch, decode,
// memory access, ALU execution, branch and jump steps. It waits on the memory
// handshake, and it drops into a sticky HALT on an illegal opcode or when
// memory does not answer within MEM_TIMEOUT cycles.
//
// Configuration:
//   MC_ADDI_EN  when defined, opcode 001000 (addi) runs EXEC_I -> IWB.
//               When undefined, addi is treated as an illegal opcode.
//
// Parameters:
//   MEM_TIMEOUT     number of consecutive memReady=0 cycles tolerated in a
//                   wait state (1..255)
//
// Ports:
//   Clk             system clock, all state updates on the rising edge
//   Rst             asynchronous active-high reset
//   opcode[5:0]     instruction[31:26]
//   funcBits[5:0]   instruction[5:0], reserved for fault tagging
//   memReady        memory handshake; an access completes in the cycle it is 1
//   controlUnitSig  [0]pcWrite [1]pcWriteCond [2]irWrite [3]writeSig
//                   [4]memRead [5]memWrite [6]iorD [7]regDst [8]memToReg
//                   [9]aluSrcA [11:10]aluOp
//   aluSrcB[1:0]    00 regB, 01 const 4, 10 signExtend, 11 signExtend<<2
//   pcSource[1:0]   00 ALU result, 01 ALUOut, 10 jump target
//   state[3:0]      current state encoding (debug)
//   fault           sticky fault flag, cleared only by Rst
//   faultCode[1:0]  01 illegal opcode, 10 memory timeout
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funcBits,
    input  logic        memReady,
    output logic [11:0] controlUnitSig,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  pcSource,
    output logic [3:0]  state,
    output logic        fault,
    output logic [1:0]  faultCode
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC_R = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        EXEC_I = 4'd10,
        IWB    = 4'd11,
        HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t      cur_state;
    state_t      nxt_state;
    logic [7:0]  wait_cnt;
    logic        mem_wait;
    logic [1:0]  fault_code_nxt;

    // funcBits feeds no logic yet; the reduction keeps it visibly consumed
    // until fault tagging is wired in.
    logic        unused_func;
    assign unused_func = ^funcBits;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statements can leave it unassigned and infer a latch.
    always_comb begin
        nxt_state      = cur_state;
        fault_code_nxt = FC_NONE;
        mem_wait       = 1'b0;

        case (cur_state)
            FETCH: begin
                if (memReady) nxt_state = DECODE;
                else          mem_wait  = 1'b1;
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE:      nxt_state = EXEC_R;
                    OP_LW, OP_SW:  nxt_state = MEMADR;
                    OP_BEQ:        nxt_state = BRANCH;
                    OP_J:          nxt_state = JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:       nxt_state = EXEC_I;
`endif
                    default: begin
                        nxt_state      = HALT;
                        fault_code_nxt = FC_ILLEGAL;
                    end
                endcase
            end
            MEMADR:  nxt_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                if (memReady) nxt_state = MEMWB;
                else          mem_wait  = 1'b1;
            end
            MEMWR: begin
                if (memReady) nxt_state = FETCH;
                else          mem_wait  = 1'b1;
            end
            MEMWB:   nxt_state = FETCH;
            EXEC_R:  nxt_state = ALUWB;
            ALUWB:   nxt_state = FETCH;
            BRANCH:  nxt_state = FETCH;
            JUMP:    nxt_state = FETCH;
`ifdef MC_ADDI_EN
            EXEC_I:  nxt_state = IWB;
            IWB:     nxt_state = FETCH;
`endif
            HALT:    nxt_state = HALT;
            default: nxt_state = FETCH;
        endcase

        // The counter value is the number of waiting cycles already spent, so
        // this cycle is the MEM_TIMEOUT-th. memReady=1 never sets mem_wait,
        // which lets a last-moment completion win over the timeout.
        if (mem_wait && (wait_cnt + 8'd1 == TIMEOUT_CNT)) begin
            nxt_state      = HALT;
            fault_code_nxt = FC_TIMEOUT;
        end
    end

    // -------------------------------------------------------------------------
    // State, wait counter and sticky fault registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cur_state <= FETCH;
            wait_cnt  <= 8'd0;
            fault     <= 1'b0;
            faultCode <= FC_NONE;
        end else begin
            cur_state <= nxt_state;
            if (nxt_state != cur_state) wait_cnt <= 8'd0;
            else if (mem_wait)          wait_cnt <= wait_cnt + 8'd1;
            // Capture only on HALT entry; HALT is left only through Rst.
            if (nxt_state == HALT && cur_state != HALT) begin
                fault     <= 1'b1;
                faultCode <= fault_code_nxt;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output decode: function of registered state and memReady only
    // -------------------------------------------------------------------------
    logic       pcWrite, pcWriteCond, irWrite, writeSig;
    logic       memRead, memWrite, iorD, regDst, memToReg, aluSrcA;
    logic [1:0] aluOp;

    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        irWrite     = 1'b0;
        writeSig    = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        iorD        = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        aluSrcA     = 1'b0;
        aluOp       = 2'b00;
        aluSrcB     = 2'b00;
        pcSource    = 2'b00;

        case (cur_state)
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
            end
            DECODE:  aluSrcB = 2'b11;
            MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            MEMWB: begin
                writeSig = 1'b1;
                memToReg = 1'b1;
            end
            EXEC_R: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
            end
            ALUWB: begin
                writeSig = 1'b1;
                regDst   = 1'b1;
            end
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
`ifdef MC_ADDI_EN
            EXEC_I: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            IWB:     writeSig = 1'b1;
`endif
            default: ;  // HALT and unused encodings drive all controls low
        endcase
    end

    assign controlUnitSig = {aluOp, aluSrcA, memToReg, regDst, iorD,
                             memWrite, memRead, writeSig, irWrite,
                             pcWriteCond, pcWrite};
    assign state          = cur_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Each instruction is expanded into an expected per-cycle trace of
// (state, memReady, fault, faultCode) from its phase list and random wait
// lengths. The trace is then replayed against the DUT. Control outputs are
// predicted from the per-state control table.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    localparam int TO = 15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [5:0]  opcode;
    logic [5:0]  funcBits;
    logic        memReady;
    logic [11:0] controlUnitSig;
    logic [1:0]  aluSrcB;
    logic [1:0]  pcSource;
    logic [3:0]  state;
    logic        fault;
    logic [1:0]  faultCode;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int         st;
        bit         mr;
        bit         flt;
        logic [1:0] code;
    } step_t;

    step_t trace[$];

    always #5 Clk = ~Clk;

    multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .opcode         (opcode),
        .funcBits       (funcBits),
        .memReady       (memReady),
        .controlUnitSig (controlUnitSig),
        .aluSrcB        (aluSrcB),
        .pcSource       (pcSource),
        .state          (state),
        .fault          (fault),
        .faultCode      (faultCode)
    );

    // Control table: {pcSource, aluSrcB, controlUnitSig} for a state.
    function automatic logic [15:0] exp_out(int st, bit mr);
        logic [11:0] c = '0;
        logic [1:0]  b = '0;
        logic [1:0]  p = '0;
        case (st)
            0:  begin c[4] = 1; b = 2'b01; if (mr) begin c[2] = 1; c[0] = 1; end end
            1:  b = 2'b11;
            2:  begin c[9] = 1; b = 2'b10; end
            3:  begin c[4] = 1; c[6] = 1; end
            4:  begin c[3] = 1; c[8] = 1; end
            5:  begin c[5] = 1; c[6] = 1; end
            6:  begin c[9] = 1; c[11:10] = 2'b10; end
            7:  begin c[3] = 1; c[7] = 1; end
            8:  begin c[9] = 1; c[11:10] = 2'b01; c[1] = 1; p = 2'b01; end
            9:  begin c[0] = 1; p = 2'b10; end
            10: begin c[9] = 1; b = 2'b10; end
            11: c[3] = 1;
            default: ;
        endcase
        return {p, b, c};
    endfunction

    function automatic bit addi_enabled();
`ifdef MC_ADDI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_J) || (op == OP_ADDI && addi_enabled());
    endfunction

    task automatic push(int st, bit mr, bit flt = 1'b0, logic [1:0] code = 2'b00);
        step_t s;
        s.st = st; s.mr = mr; s.flt = flt; s.code = code;
        trace.push_back(s);
    endtask

    // A memory phase: `waits` idle cycles, then the completing cycle.
    task automatic add_mem(int st, int waits);
        for (int i = 0; i < waits; i++) push(st, 1'b0);
        push(st, 1'b1);
    endtask

    task automatic add_halt(logic [1:0] code);
        for (int i = 0; i < 3; i++) push(15, 1'($urandom_range(0, 1)), 1'b1, code);
    endtask

    task automatic build_instr(logic [5:0] op, int fw, int mw);
        add_mem(0, fw);
        push(1, 1'($urandom_range(0, 1)));
        if (!is_legal(op)) begin
            add_halt(2'b01);
        end else begin
            case (op)
                OP_R:    begin push(6, 1'($urandom_range(0, 1))); push(7, 1'($urandom_range(0, 1))); end
                OP_LW:   begin push(2, 1'($urandom_range(0, 1))); add_mem(3, mw); push(4, 1'($urandom_range(0, 1))); end
                OP_SW:   begin push(2, 1'($urandom_range(0, 1))); add_mem(5, mw); end
                OP_BEQ:  push(8, 1'($urandom_range(0, 1)));
                OP_J:    push(9, 1'($urandom_range(0, 1)));
                default: begin push(10, 1'($urandom_range(0, 1))); push(11, 1'($urandom_range(0, 1))); end
            endcase
        end
    endtask

    // Replays the trace; entered and left at posedge+1.
    task automatic play(string name);
        logic [15:0] got, want;
        for (int i = 0; i < trace.size(); i++) begin
            memReady = trace[i].mr;
            funcBits = 6'($urandom);
            #1;
            got  = {pcSource, aluSrcB, controlUnitSig};
            want = exp_out(trace[i].st, trace[i].mr);
            checks++;
            if (state !== 4'(trace[i].st) || got !== want ||
                fault !== trace[i].flt || faultCode !== trace[i].code)
                $display("FAIL %s step %0d: got st=%0d out=%h flt=%b code=%b, expected st=%0d out=%h flt=%b code=%b",
                         name, i, state, got, fault, faultCode,
                         trace[i].st, want, trace[i].flt, trace[i].code);
            else
                passes++;
            @(posedge Clk);
            #1;
        end
        trace.delete();
    endtask

    task automatic reset_dut();
        Rst      = 1'b1;
        memReady = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1 Rst = 1'b0;
        trace.delete();
    endtask

    task automatic test_reset();
        opcode   = OP_LW;
        funcBits = 6'd0;
        reset_dut();
        build_instr(OP_LW, 0, 0);
        trace = trace[0:2];   // stop in MEMADR
        play("pre_reset");
        #2 Rst = 1'b1;
        memReady = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || fault !== 1'b0 || faultCode !== 2'b00 ||
            {pcSource, aluSrcB, controlUnitSig} !== exp_out(0, 1'b0))
            $display("FAIL reset_async: got st=%0d out=%h flt=%b code=%b, expected st=0 out=%h flt=0 code=0",
                     state, {pcSource, aluSrcB, controlUnitSig}, fault, faultCode, exp_out(0, 1'b0));
        else
            passes++;
        @(posedge Clk);
        #1 Rst = 1'b0;
    endtask

    task automatic test_cycle_counts();
        logic [5:0] ops[6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        int         want[6] = '{4, 5, 4, 3, 3, 4};
        int         cnt;
        for (int k = 0; k < 6; k++) begin
            if (ops[k] == OP_ADDI && !addi_enabled()) continue;
            reset_dut();
            opcode   = ops[k];
            memReady = 1'b1;
            cnt = 0;
            do begin
                @(posedge Clk);
                cnt++;
                #1;
            end while (state !== 4'd0 && cnt < 50);
            checks++;
            if (cnt !== want[k])
                $display("FAIL cycles op=%b: got %0d cycles, expected %0d", ops[k], cnt, want[k]);
            else
                passes++;
        end
    endtask

    task automatic test_mem_waits();
        reset_dut();
        opcode = OP_SW;
        build_instr(OP_SW, 0, 3);      // memWrite held 4 cycles, no fault
        play("sw_wait3");
        opcode = OP_LW;
        build_instr(OP_LW, TO - 1, TO - 1);   // completion in the last legal cycle
        play("lw_wait_edge");
    endtask

    task automatic test_random();
        logic [5:0] ops[6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        int         n;
        reset_dut();
        for (int i = 0; i < 40; i++) begin
            n = addi_enabled() ? 5 : 4;
            opcode = ops[$urandom_range(0, n)];
            build_instr(opcode,
                        ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3)),
                        ($urandom_range(0, 7) == 0) ? TO - 1 : int'($urandom_range(0, 3)));
            play("random");
        end
    endtask

    task automatic test_timeout();
        reset_dut();
        opcode = OP_R;
        for (int i = 0; i < TO; i++) push(0, 1'b0);
        add_halt(2'b10);
        play("fetch_timeout");

        reset_dut();
        opcode = OP_SW;
        push(0, 1'b1);
        push(1, 1'b0);
        push(2, 1'b1);
        for (int i = 0; i < TO; i++) push(5, 1'b0);
        add_halt(2'b10);
        play("memwr_timeout");
    endtask

    task automatic test_illegal();
        logic [5:0] op;
        reset_dut();
        opcode = 6'b111111;
        build_instr(opcode, 1, 0);
        play("illegal_3f");
        #2 Rst = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || fault !== 1'b0 || faultCode !== 2'b00)
            $display("FAIL halt_reset: got st=%0d flt=%b code=%b, expected st=0 flt=0 code=0",
                     state, fault, faultCode);
        else
            passes++;
        @(posedge Clk);
        #1 Rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            reset_dut();
            do op = 6'($urandom); while (is_legal(op));
            opcode = op;
            build_instr(op, int'($urandom_range(0, 2)), 0);
            play("illegal_rand");
        end
    endtask

    task automatic test_addi();
        reset_dut();
        opcode = OP_ADDI;
        build_instr(OP_ADDI, 0, 0);   // EXEC_I/IWB or HALT 01, depending on build
        play("addi");
    endtask

    task automatic test_reset_mid_wait();
        reset_dut();
        opcode = OP_LW;
        push(0, 1'b1);
        push(1, 1'b1);
        push(2, 1'b1);
        for (int i = 0; i < 4; i++) push(3, 1'b0);
        play("lw_pre_reset");
        Rst = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || controlUnitSig[3] !== 1'b0 || controlUnitSig[5] !== 1'b0)
            $display("FAIL reset_mid_wait: got st=%0d writeSig=%b memWrite=%b, expected st=0 writeSig=0 memWrite=0",
                     state, controlUnitSig[3], controlUnitSig[5]);
        else
            passes++;
        @(posedge Clk);
        #1 Rst = 1'b0;
        build_instr(OP_LW, 2, 1);
        play("lw_after_reset");
    endtask

    initial begin
        Rst      = 1'b1;
        opcode   = 6'd0;
        funcBits = 6'd0;
        memReady = 1'b0;
        test_reset();
        test_cycle_counts();
        test_mem_waits();
        test_random();
        test_timeout();
        test_illegal();
        test_addi();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
